// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter sharing one uart_tx between NUM_REQ requesters in the
// core clock domain. A granted requester's character is latched onto tx_data,
// tx_wr is held high for WR_PULSE core cycles so the slower, divided uart_tx
// clock is sure to see it, and acceptance is confirmed by tx_buffempty
// falling. The winner gets a one-cycle ack; a transfer that is never accepted
// within ACK_TIMEOUT cycles raises a sticky timeout flag instead.
//
// Ports:
//   i_clk            core clock
//   i_rst            synchronous active-high reset
//   i_en             1 = new grants allowed; 0 = finish current transfer, hold
//   i_req            level request per requester
//   i_req_data       requester i character at [i*DATA_W +: DATA_W]
//   o_ack            one-cycle pulse, requester's character accepted
//   o_tx_data        character to uart_tx
//   o_tx_wr          write strobe to uart_tx
//   i_tx_buffempty   uart_tx buffer-empty status
//   o_busy           1 while a transfer is in progress
//   o_cur_src        requester being served or last served
//   o_timeout_err    sticky acceptance-timeout flag
//   o_err_src        requester of the most recent timeout
//   i_err_clr        clears o_timeout_err (a same-cycle timeout wins)
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 9,
    parameter int unsigned WR_PULSE    = 4,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned SRC_W       = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [DATA_W-1:0]         o_tx_data,
    output logic                      o_tx_wr,
    input  logic                      i_tx_buffempty,
    output logic                      o_busy,
    output logic [SRC_W-1:0]          o_cur_src,
    output logic                      o_timeout_err,
    output logic [SRC_W-1:0]          o_err_src,
    input  logic                      i_err_clr
);

    // One counter serves both the write pulse and the acceptance timeout.
    localparam int unsigned CNT_MAX = (WR_PULSE > ACK_TIMEOUT) ? WR_PULSE : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WRITE       = 2'd1,
        S_WAIT_ACCEPT = 2'd2
    } state_t;

    state_t              r_state;
    logic [SRC_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_tx_wr;
    logic                r_busy;
    logic [SRC_W-1:0]    r_cur_src;
    logic                r_timeout_err;
    logic [SRC_W-1:0]    r_err_src;

    logic [DATA_W-1:0]   w_req_data [NUM_REQ];
    logic [SRC_W-1:0]    w_sel;
    logic                w_any;
    int unsigned         w_idx;
    logic [SRC_W-1:0]    w_ptr_next;

    // Split the flat data bus into one character per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_data[g] = i_req_data[g*DATA_W +: DATA_W];
    end

    // Round-robin pick: first set request starting at r_ptr, wrapping.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        w_idx = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = 32'(r_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_any && i_req[w_idx]) begin
                w_any = 1'b1;
                w_sel = SRC_W'(w_idx);
            end
        end
    end

    // Pointer moves just past the requester that finished (ack or timeout).
    assign w_ptr_next = (r_cur_src == SRC_W'(NUM_REQ - 1)) ? '0 : r_cur_src + SRC_W'(1);

    // Arbitration / transfer state machine with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_ack         <= '0;
            r_tx_data     <= '0;
            r_tx_wr       <= 1'b0;
            r_busy        <= 1'b0;
            r_cur_src     <= '0;
            r_timeout_err <= 1'b0;
            r_err_src     <= '0;
        end else begin
            r_ack <= '0;
            // A timeout raised below in the same cycle overrides this clear.
            if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // uart_tx must be ready before a new character is offered.
                    if (i_en && i_tx_buffempty && w_any) begin
                        r_cur_src <= w_sel;
                        r_tx_data <= w_req_data[w_sel];
                        r_tx_wr   <= 1'b1;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    // tx_wr was raised on the grant edge; drop it after WR_PULSE cycles.
                    if (r_cnt == CNT_W'(WR_PULSE - 1)) begin
                        r_tx_wr <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_ACCEPT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WAIT_ACCEPT: begin
                    if (!i_tx_buffempty) begin
                        r_ack   <= NUM_REQ'(1) << r_cur_src;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_W'(ACK_TIMEOUT)) begin
                        r_timeout_err <= 1'b1;
                        r_err_src     <= r_cur_src;
                        r_ptr         <= w_ptr_next;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_tx_wr <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack         = r_ack;
    assign o_tx_data     = r_tx_data;
    assign o_tx_wr       = r_tx_wr;
    assign o_busy        = r_busy;
    assign o_cur_src     = r_cur_src;
    assign o_timeout_err = r_timeout_err;
    assign o_err_src     = r_err_src;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. A transaction-level reference
// model (grant time arithmetic, round-robin pick by search order) predicts
// every registered output each cycle; a simple uart_tx model answers tx_wr
// with a buffempty drop. Table-driven round-robin vectors, directed
// sequences and a randomized run are applied on top.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 9;
    localparam int WR_PULSE    = 4;
    localparam int ACK_TIMEOUT = 64;
    localparam int SRC_W       = $clog2(NUM_REQ);
    localparam int TO_K        = WR_PULSE + 1 + ACK_TIMEOUT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic                      en;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_wr;
    logic                      tx_buffempty;
    logic                      busy;
    logic [SRC_W-1:0]          cur_src;
    logic                      timeout_err;
    logic [SRC_W-1:0]          err_src;
    logic                      err_clr;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .WR_PULSE   (WR_PULSE),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_req         (req),
        .i_req_data    (req_data),
        .o_ack         (ack),
        .o_tx_data     (tx_data),
        .o_tx_wr       (tx_wr),
        .i_tx_buffempty(tx_buffempty),
        .o_busy        (busy),
        .o_cur_src     (cur_src),
        .o_timeout_err (timeout_err),
        .o_err_src     (err_src),
        .i_err_clr     (err_clr)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_seen = 0;

    // Requester-side stimulus
    logic [NUM_REQ-1:0] rq;
    logic [DATA_W-1:0]  rd [NUM_REQ];
    logic               en_v, clr_v, rst_v, be_v;

    // uart_tx model: buffempty falls um_dly cycles after wr falls, for um_len cycles
    int um_drop, um_hold, um_dly, um_len;
    bit um_stuck, um_force_low;

    // Reference model state (expected outputs after the latest edge)
    bit                 m_busy = 1'b0;
    int                 m_g, m_sel, m_ptr, m_cur, m_esrc;
    logic [NUM_REQ-1:0] m_ack;
    logic               m_wr = 1'b0;
    logic [DATA_W-1:0]  m_data;
    logic               m_terr;

    typedef struct {
        logic [NUM_REQ-1:0] req;
        int                 winner;
    } rr_vec_t;
    rr_vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Predict the outputs produced by the upcoming edge from the current inputs.
    task automatic model_edge();
        int k;
        m_ack = '0;
        if (rst_v) begin
            m_busy = 1'b0; m_ptr = 0; m_wr = 1'b0; m_data = '0;
            m_cur = 0; m_terr = 1'b0; m_esrc = 0;
        end else begin
            if (clr_v) m_terr = 1'b0;
            if (!m_busy) begin
                if (en_v && be_v && rq != '0) begin
                    m_sel  = rr_pick(rq, m_ptr);
                    m_busy = 1'b1;
                    m_g    = cyc;
                    m_data = rd[m_sel];
                    m_cur  = m_sel;
                    m_wr   = 1'b1;
                end
            end else begin
                k    = cyc - m_g;
                m_wr = (k < WR_PULSE);
                if (k > WR_PULSE) begin
                    if (!be_v) begin
                        m_ack[m_sel] = 1'b1;
                        m_busy = 1'b0;
                        m_ptr  = (m_sel + 1) % NUM_REQ;
                    end else if (k == TO_K) begin
                        m_terr = 1'b1;
                        m_esrc = m_sel;
                        m_busy = 1'b0;
                        m_ptr  = (m_sel + 1) % NUM_REQ;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs #1 after the edge.
    task automatic step(input string tag);
        logic prev_wr;
        be_v = um_force_low ? 1'b0 : ((um_hold > 0) ? 1'b0 : 1'b1);
        rst = rst_v; en = en_v; req = rq; err_clr = clr_v; tx_buffempty = be_v;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = rd[i];
        prev_wr = m_wr;
        cyc++;
        model_edge();
        @(posedge clk);
        #1;
        chk(tag, 32'({ack, tx_wr, tx_data, busy, cur_src, timeout_err, err_src}),
                 32'({m_ack, m_wr, m_data, m_busy, SRC_W'(m_cur), m_terr, SRC_W'(m_esrc)}));
        if (tx_wr === 1'b1) wr_seen++;
        if (um_hold > 0) um_hold--;
        if (um_drop > 0) begin
            um_drop--;
            if (um_drop == 0) um_hold = um_len;
        end
        if (prev_wr && !m_wr && !um_stuck && !rst_v) um_drop = um_dly;
    endtask

    task automatic do_reset();
        rst_v = 1'b1; um_drop = 0; um_hold = 0; um_force_low = 1'b0; um_stuck = 1'b0;
        um_dly = 3; um_len = 40;
        step("reset_cycle");
        rst_v = 1'b0;
        chk("reset_outputs", 32'({ack, tx_wr, tx_data, busy, cur_src, timeout_err, err_src}), 32'd0);
    endtask

    task automatic wait_ack(input string tag, input int bound, output int idx, output logic [DATA_W-1:0] dat);
        idx = -1;
        dat = '0;
        for (int n = 0; n < bound && idx < 0; n++) begin
            step(tag);
            if (ack != '0) begin
                idx = oh_idx(ack);
                dat = tx_data;
            end
        end
        if (idx < 0) chk({tag, "_ack_wait_expired"}, 32'd0, 32'd1);
    endtask

    task automatic wait_wr(input string tag, input int bound);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            step(tag);
            if (tx_wr === 1'b1) seen = 1'b1;
        end
        if (!seen) chk({tag, "_wr_wait_expired"}, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, gcyc;
        bit ack_any;
        logic [DATA_W-1:0] dat;
        int exp_order [6];
        int rot_order [4];

        tbl[0] = '{4'b0001, 0}; tbl[1] = '{4'b0001, 0}; tbl[2] = '{4'b1001, 3};
        tbl[3] = '{4'b1111, 0}; tbl[4] = '{4'b1101, 2}; tbl[5] = '{4'b0011, 0};
        tbl[6] = '{4'b0110, 1}; tbl[7] = '{4'b1010, 3}; tbl[8] = '{4'b1000, 3};
        tbl[9] = '{4'b0101, 0};
        exp_order = '{0, 1, 2, 3, 0, 1};
        rot_order = '{2, 0, 2, 0};

        rq = '0; en_v = 1'b1; clr_v = 1'b0; rst_v = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = '0;
        um_force_low = 1'b0; um_stuck = 1'b0; um_drop = 0; um_hold = 0;

        // Single character
        do_reset();
        wr_seen = 0;
        rq = 4'b0001; rd[0] = 9'h055;
        wait_ack("t1", 200, idx, dat);
        chk("t1_ack_vec", 32'(ack), 32'b0001);
        chk("t1_data", 32'(dat), 32'h055);
        rq = '0;
        step("t1_after");
        chk("t1_ack_one_cycle", 32'(ack), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_cur_src", 32'(cur_src), 32'd0);
        chk("t1_wr_cycles", 32'(wr_seen), 32'(WR_PULSE));

        // Table-driven round-robin vectors (ptr walks from 0)
        do_reset();
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < NUM_REQ; j++) rd[j] = DATA_W'(16 * r + j);
            rq = tbl[r].req;
            wait_ack("tbl", 200, idx, dat);
            chk("tbl_winner", 32'(idx), 32'(tbl[r].winner));
            chk("tbl_data", 32'(dat), 32'(16 * r + tbl[r].winner));
            rq = '0;
        end

        // Fairness with all four requesting
        do_reset();
        rq = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = DATA_W'(9'h0A0 + i);
        for (int j = 0; j < 6; j++) begin
            wait_ack("t2", 300, idx, dat);
            chk("t2_order", 32'(idx), 32'(exp_order[j]));
            chk("t2_data", 32'(dat), 32'(9'h0A0 + exp_order[j]));
            chk("t2_single_ack", 32'($countones(ack)), 32'd1);
        end
        rq = '0;

        // Rotation: req[0] raised while 2 is served
        do_reset();
        rq = 4'b0100; rd[2] = 9'h0C2; rd[0] = 9'h0C0;
        wait_wr("t3_first_grant", 50);
        rq[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_ack("t3", 300, idx, dat);
            chk("t3_order", 32'(idx), 32'(rot_order[j]));
        end
        rq = '0;

        // Timeout, then service of the other pending requester, err_clr handling
        do_reset();
        um_stuck = 1'b1;
        rq = 4'b1010; rd[1] = 9'h1B1; rd[3] = 9'h1B3;
        wait_wr("t4_grant", 50);
        gcyc = cyc;
        chk("t4_first_src", 32'(cur_src), 32'd1);
        ack_any = 1'b0;
        for (int n = 0; n < 200 && timeout_err !== 1'b1; n++) begin
            step("t4_wait_to");
            if (ack != '0) ack_any = 1'b1;
        end
        chk("t4_timeout_latency", 32'(cyc - gcyc), 32'(TO_K));
        chk("t4_timeout_err", 32'(timeout_err), 32'd1);
        chk("t4_err_src", 32'(err_src), 32'd1);
        chk("t4_no_ack", 32'(ack_any), 32'd0);
        wait_wr("t4_next_grant", 20);
        chk("t4_next_src", 32'(cur_src), 32'd3);
        clr_v = 1'b1;
        step("t4_clr");
        clr_v = 1'b0;
        chk("t4_cleared", 32'(timeout_err), 32'd0);
        for (int n = 0; n < 200 && !(m_busy && (cyc + 1 - m_g) == TO_K); n++) step("t4_wait_to2");
        clr_v = 1'b1;
        step("t4_clr_vs_timeout");
        clr_v = 1'b0;
        chk("t4_timeout_wins", 32'(timeout_err), 32'd1);
        chk("t4_err_src2", 32'(err_src), 32'd3);
        rq = '0; um_stuck = 1'b0;

        // Enable gating and buffempty gating
        do_reset();
        en_v = 1'b0; rq = 4'b0100; rd[2] = 9'h0E2; wr_seen = 0;
        for (int n = 0; n < 100; n++) step("t5_en_off");
        chk("t5_no_wr_when_disabled", 32'(wr_seen), 32'd0);
        en_v = 1'b1;
        step("t5_en_on");
        chk("t5_grant_wr", 32'(tx_wr), 32'd1);
        chk("t5_grant_src", 32'(cur_src), 32'd2);
        wait_ack("t5", 200, idx, dat);
        rq = '0;
        um_force_low = 1'b1;
        step("t5_idle");
        rq = 4'b0001; rd[0] = 9'h0E0; wr_seen = 0;
        for (int n = 0; n < 60; n++) step("t5_be_low");
        chk("t5_no_grant_be_low", 32'(wr_seen), 32'd0);
        um_force_low = 1'b0;
        step("t5_be_high");
        chk("t5_grant_after_be", 32'({tx_wr, cur_src}), 32'({1'b1, 2'd0}));
        wait_ack("t5b", 200, idx, dat);
        rq = '0;

        // Reset in the middle of WRITE; pointer must restart at 0
        do_reset();
        rq = 4'b0100; rd[2] = 9'h0D2;
        wait_ack("t6_first", 200, idx, dat);
        wait_wr("t6_regrant", 100);
        step("t6_wr2");
        rst_v = 1'b1;
        step("t6_reset");
        rst_v = 1'b0;
        chk("t6_after_reset", 32'({tx_wr, busy, ack}), 32'd0);
        rq = 4'b1010; rd[1] = 9'h0D1; rd[3] = 9'h0D3;
        wait_ack("t6_a", 200, idx, dat);
        chk("t6_first_after_reset", 32'(idx), 32'd1);
        rq[1] = 1'b0;
        wait_ack("t6_b", 200, idx, dat);
        chk("t6_second_after_reset", 32'(idx), 32'd3);
        rq = '0;

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 0) um_stuck = ($urandom_range(0, 3) == 0);
            if (um_drop == 0 && um_hold == 0) begin
                um_dly = $urandom_range(1, 8);
                um_len = $urandom_range(1, 30);
            end
            en_v  = ($urandom_range(0, 9) != 0);
            clr_v = ($urandom_range(0, 29) == 0);
            rst_v = ($urandom_range(0, 499) == 0);
            step("random");
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(0, 1) == 1) rd[i] = DATA_W'($urandom);
                    else rq[i] = 1'b0;
                end else if (!rq[i] && $urandom_range(0, 7) == 0) begin
                    rq[i] = 1'b1;
                    rd[i] = DATA_W'($urandom);
                end
            end
        end
        rst_v = 1'b0; clr_v = 1'b0; en_v = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx instance between NUM_REQ requesters inside the core clock domain. It selects one pending requester and drives uart_tx data and wr. It holds wr high long enough to be seen by the slower, divided peripheral clock, and confirms acceptance via buffempty. It returns a one-cycle ack to the winning requester and flags requesters whose transfer was never accepted.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 9, character width; matches the 9-bit uart_tx data port
WR_PULSE, 4, core cycles tx_wr is held high per character (>=1)
ACK_TIMEOUT, 64, core cycles to wait for tx_buffempty low after the wr pulse
SRC_W, $clog2(NUM_REQ), requester index width (derived)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
en  in  1  1 = new grants allowed; 0 = finish current transfer, then hold
req  in  NUM_REQ  level request per requester
req_data  in  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle pulse: requester's character accepted by uart_tx
tx_data  out  DATA_W  to uart_tx data
tx_wr  out  1  to uart_tx wr
tx_buffempty  in  1  from uart_tx buffempty
busy  out  1  1 when state != IDLE
cur_src  out  SRC_W  index of requester being served or last served
timeout_err  out  1  sticky, set on acceptance timeout
err_src  out  SRC_W  requester index of the most recent timeout
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (sync, at the clk edge with rst=1): state=IDLE; ptr=0; tx_wr=0; tx_data=0; ack=0; busy=0; cur_src=0; timeout_err=0; err_src=0. Reset mid-transfer aborts at once and issues no ack. A uart_tx transfer already in flight is not recalled.
- All outputs are registered.
- Round-robin search order is ptr, ptr+1, … wrapping modulo NUM_REQ. After a transfer ends (ack or timeout), ptr = (sel+1) mod NUM_REQ. Wrap example: sel=NUM_REQ-1 gives ptr=0.
- IDLE:
  - Grant when en=1, tx_buffempty=1 and req != 0.
  - On the grant edge: sel = first set req bit in search order; tx_data latches req_data[sel]; cur_src=sel; tx_wr=1; counter=0; go to WRITE.
  - If tx_buffempty=0, stay in IDLE even with requests pending.
- WRITE:
  - tx_wr is high for exactly WR_PULSE consecutive cycles, starting the cycle after the grant edge.
  - Then tx_wr=0, counter=0, go to WAIT_ACCEPT.
  - tx_data stays stable through WRITE and WAIT_ACCEPT.
- WAIT_ACCEPT:
  - First edge sampling tx_buffempty=0: ack[sel]=1 for one cycle, update ptr, go to IDLE.
  - If counter reaches ACK_TIMEOUT with tx_buffempty still 1: timeout_err=1, err_src=sel, no ack, update ptr, go to IDLE.
  - The requester stays pending; it is retried only after the others have had a turn.
- Requester contract:
  - req_data must be stable while req is high and no ack has been seen.
  - Data is latched at grant; dropping req after grant does not cancel the transfer, and ack is still pulsed.
  - At most one ack bit is set per cycle.
  - A requester may present its next character in the cycle after ack.
- en=0 only blocks the IDLE→WRITE transition; an in-flight transfer completes normally.
- err_clr clears timeout_err. A timeout set in the same cycle wins, so timeout_err=1.
- Minimum spacing between characters is governed by uart_tx: the next grant waits for tx_buffempty=1 in IDLE.

Test Plan:
1. Single character: after reset, req=4'b0001, req_data[0]=9'h055. The uart_tx model drops buffempty 3 cycles after the wr falling edge and raises it 40 cycles later. Required: tx_data=9'h055, tx_wr high exactly WR_PULSE=4 cycles, ack=4'b0001 for one cycle, busy back to 0, cur_src=0.
2. Fairness: all four req held high with data 9'h0A0..9'h0A3. Required: ack order 0,1,2,3,0,1; tx_data sequence matches that order; never two acks in one cycle.
3. Rotation: req[2] continuous, req[0] raised while 2 is being served (ptr becomes 3). Required: next grant goes to 0, then 2, then 0; no wrap error past index 3.
4. Timeout: the model holds buffempty=1 always; req[1] set with ACK_TIMEOUT=64. Required: timeout_err=1 and err_src=1 at cycle 1+4+64 after grant, no ack; req[3] pending is served next. err_clr pulse returns timeout_err to 0; err_clr asserted in the same cycle as a new timeout leaves timeout_err=1.
5. Enable and busy gating: en=0 with req=4'b0100 gives no tx_wr for 100 cycles; en=1 gives a grant to 2 on the next edge. With buffempty=0 in IDLE, no grant occurs until it rises.
6. Reset mid-WRITE: rst=1 on the 2nd tx_wr cycle. Required: the next edge shows tx_wr=0, busy=0, ack=0, ptr=0. After release with req=4'b1010, index 1 is served before index 3.
